// File: rtl/spi_responder.sv
// spi_responder: 16-bit SPI slave for the frame link driven by our SPI master.
//
// Bus mode: sclk idles high, miso changes on sclk fall, mosi is sampled on
// sclk rise, MSB first, 16 bits per frame framed by active-low ss_n.
// All SPI pins are oversampled by clk through SYNC_STAGES-deep synchronizers.
// The master must keep each sclk half-period at SYNC_STAGES+3 clk cycles or more.
//
// Optional feature, macro SPI_RESPONDER_RX_HANDSHAKE_EN:
//   defined   - rx_valid is a level cleared by rx_ack; an unread word that is
//               overwritten raises a one-cycle rx_overrun pulse.
//   undefined - rx_valid is a one-cycle pulse, rx_ack is ignored and
//               rx_overrun stays 0.
//
// Handshakes:
//   tx side : a word is accepted when tx_load=1 and tx_ready=1 in the same clk
//             cycle; tx_load while tx_ready=0 is dropped and the held word is kept.
//   rx side : rx_valid marks rx_data as a new word (a pulse, or a level held
//             until rx_ack when the handshake feature is built in).

module spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] IDLE_FILL   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    input  logic        rx_ack,
    output logic        rx_overrun
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        WAIT_DESEL = 2'd2
    } state_t;

    state_t state;

    // Synchronizer chains; the last stage is the usable in-domain copy.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    // One extra delay flop per edge-detected signal.
    logic sclk_d;
    logic ss_d;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;

    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    // Shift registers, bit counter and the tx holding register.
    logic [15:0] txsr;
    logic [15:0] rxsr;
    logic [3:0]  bit_cnt;
    logic [15:0] hold_word;
    logic        hold_full;
    logic        overrun_q;
    logic [15:0] rx_word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    // Word completed by the current rising edge, including the bit sampled now.
    assign rx_word = {rxsr[14:0], mosi_s};

    assign tx_ready   = ~hold_full;
    assign rx_overrun = overrun_q;

`ifndef SPI_RESPONDER_RX_HANDSHAKE_EN
    // rx_ack has no function when rx_valid is a plain pulse.
    logic unused_rx_ack;
    assign unused_rx_ack = rx_ack;
`endif

    // Pin synchronizers plus edge-detect delay flops; idle levels on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b1;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Frame FSM with registered outputs and the tx holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            bit_cnt   <= 4'd0;
            txsr      <= 16'd0;
            rxsr      <= 16'd0;
            rx_data   <= 16'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun_q <= 1'b0;
            hold_word <= 16'd0;
            hold_full <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SPI_RESPONDER_RX_HANDSHAKE_EN
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end
`else
            rx_valid <= 1'b0;
`endif

            // A load is only taken while the holding register is empty. If the
            // frame starts in the same cycle with the register empty, the frame
            // uses IDLE_FILL and this word waits for the next frame.
            if (tx_load && !hold_full) begin
                hold_word <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso    <= 1'b1;
                    miso_oe <= 1'b0;
                    if (ss_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= 4'd0;
                        miso_oe <= 1'b1;
                        if (hold_full) begin
                            // tx_ready was 0, so no load can collide with this clear.
                            txsr      <= hold_word;
                            hold_full <= 1'b0;
                        end else begin
                            txsr <= IDLE_FILL;
                        end
                    end
                end

                SHIFT: begin
                    if (sclk_rise && bit_cnt == 4'd15) begin
                        // Completion wins over a deselect seen in the same cycle.
                        rxsr     <= rx_word;
                        rx_data  <= rx_word;
                        rx_valid <= 1'b1;
                        bit_cnt  <= 4'd0;
`ifdef SPI_RESPONDER_RX_HANDSHAKE_EN
                        if (rx_valid && !rx_ack) begin
                            overrun_q <= 1'b1;
                        end
`endif
                        if (ss_rise) begin
                            state   <= IDLE;
                            miso    <= 1'b1;
                            miso_oe <= 1'b0;
                        end else begin
                            state <= WAIT_DESEL;
                        end
                    end else if (ss_rise) begin
                        // Deselect before the 16th rise: drop the partial word.
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        miso      <= 1'b1;
                        miso_oe   <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            miso <= txsr[15];
                            txsr <= {txsr[14:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rxsr    <= rx_word;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                WAIT_DESEL: begin
                    // Extra sclk edges are ignored; miso keeps its last bit.
                    if (ss_rise) begin
                        state   <= IDLE;
                        miso    <= 1'b1;
                        miso_oe <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    miso    <= 1'b1;
                    miso_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed bench for spi_responder with a frame-level model.
// The model tracks the tx holding register as "word pending or not", the words
// each complete frame must deliver, and the frame_err/rx_overrun events owed.
`timescale 1ns/1ps

module tb_spi_responder;

  localparam int          SYNC = 2;
  localparam logic [15:0] FILL = 16'hFFFF;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        rx_ack;
  logic        rx_overrun;

  spi_responder #(
    .SYNC_STAGES(SYNC),
    .IDLE_FILL  (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_ack    (rx_ack),
    .rx_overrun(rx_overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_checks;
  int          n_fail;
  logic [15:0] exp_q[$];
  int          exp_err;
  int          exp_ovr;
  logic        model_hold_valid;
  logic [15:0] model_hold_word;
  int          ss_hi_cnt;
  int          ss_lo_cnt;
  int          rst_lo_cnt;
  logic        rx_valid_prev;
  logic        rx_event;
  logic [15:0] exp_word;
  bit          auto_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (ss_n) begin
      ss_hi_cnt++;
      ss_lo_cnt = 0;
    end else begin
      ss_lo_cnt++;
      ss_hi_cnt = 0;
    end
    if (rst) rst_lo_cnt = 0;
    else rst_lo_cnt++;

    check("tx_ready", tx_ready, !model_hold_valid);
    if (ss_hi_cnt >= 8) begin
      check("idle_miso", miso, 1);
      check("idle_miso_oe", miso_oe, 0);
    end
    if (ss_lo_cnt >= 8 && rst_lo_cnt > ss_lo_cnt) check("sel_miso_oe", miso_oe, 1);

`ifdef SPI_RESPONDER_RX_HANDSHAKE_EN
    rx_event = (rx_valid && !rx_valid_prev) || rx_overrun;
`else
    rx_event = rx_valid || rx_overrun;
`endif
    if (rx_event) begin
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", 1, 0);
      end else begin
        exp_word = exp_q.pop_front();
        check("rx_data", rx_data, exp_word);
      end
    end
    if (frame_err) begin
      check("frame_err_expected", (exp_err > 0), 1);
      if (exp_err > 0) exp_err--;
    end
    if (rx_overrun) begin
      check("rx_overrun_expected", (exp_ovr > 0), 1);
      if (exp_ovr > 0) exp_ovr--;
    end
    rx_valid_prev = rx_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tx_load_word(input logic [15:0] w);
    @(posedge clk); #1;
    tx_data = w;
    tx_load = 1'b1;
    @(posedge clk); #1;
    tx_load = 1'b0;
    if (!model_hold_valid) begin
      model_hold_valid = 1'b1;
      model_hold_word  = w;
    end
  endtask

  task automatic check_reset_values();
    check("rst_miso", miso, 1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_overrun", rx_overrun, 0);
  endtask

  // end_mode: 0 = deselect after the last bit, 1 = deselect together with the
  // last rising edge, 2 = assert rst after the last bit (frame aborted by reset).
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int half,
                           input bit start_load, input logic [15:0] start_word,
                           input int mid_at, input logic [15:0] mid_word,
                           input int end_mode, output logic [15:0] miso_word);
    logic [15:0] exp_tx;
    logic        prev_full;
    miso_word = 16'h0000;
    if (nbits == 16 && end_mode != 2) exp_q.push_back(word);
    else if (end_mode == 0) exp_err++;

    @(posedge clk); #1;
    ss_n = 1'b0;
    // The responder registers the frame start SYNC+1 clk edges after ss_n falls.
    if (start_load) begin
      repeat (SYNC) @(posedge clk);
      #1;
      tx_data = start_word;
      tx_load = 1'b1;
      @(posedge clk); #1;
      tx_load = 1'b0;
    end else begin
      repeat (SYNC + 1) @(posedge clk);
      #1;
    end
    prev_full        = model_hold_valid;
    exp_tx           = prev_full ? model_hold_word : FILL;
    model_hold_valid = 1'b0;
    if (start_load && !prev_full) begin
      model_hold_valid = 1'b1;
      model_hold_word  = start_word;
    end

    repeat (half) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = word[15-i];
      repeat (half) @(posedge clk);
      #1;
      miso_word[15-i] = miso;
      if (end_mode == 1 && i == nbits - 1) ss_n = 1'b1;
      sclk = 1'b1;
      if (i + 1 == mid_at) tx_load_word(mid_word);
      repeat (half) @(posedge clk);
      #1;
    end

    if (end_mode == 2) begin
      rst = 1'b1;
      @(posedge clk); #1;
      model_hold_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      ss_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      ss_n = 1'b1;
    end
    repeat (12) @(posedge clk);
    #1;
    if (nbits == 16 && end_mode != 2) check("miso_word_model", miso_word, exp_tx);
  endtask

  task automatic wait_drain();
    int budget = 200;
    while ((exp_q.size() != 0 || exp_err != 0 || exp_ovr != 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_in_time", (budget > 0), 1);
`ifdef SPI_RESPONDER_RX_HANDSHAKE_EN
    if (auto_ack && rx_valid) begin
      rx_ack = 1'b1;
      @(posedge clk); #1;
      rx_ack = 1'b0;
      check("ack_clears_rx_valid", rx_valid, 0);
    end
`endif
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [15:0] mw;
    n_checks = 0;
    n_fail = 0;
    exp_err = 0;
    exp_ovr = 0;
    model_hold_valid = 1'b0;
    model_hold_word = 16'h0000;
    ss_hi_cnt = 0;
    ss_lo_cnt = 0;
    rst_lo_cnt = 0;
    rx_valid_prev = 1'b0;
    auto_ack = 1'b1;
    rst = 1'b1;
    sclk = 1'b1;
    ss_n = 1'b1;
    mosi = 1'b0;
    tx_data = 16'h0000;
    tx_load = 1'b0;
    rx_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Basic frame at the slow half-period.
    tx_load_word(16'hA5C3);
    check("tx_ready_after_load", tx_ready, 0);
    spi_frame(16'h0B2D, 16, 256, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("basic_miso", mw, 16'hA5C3);
    check("basic_rx_data", rx_data, 16'h0B2D);
    check("basic_tx_ready", tx_ready, 1);

    // Empty holding register: idle fill goes out.
    spi_frame(16'h5A69, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("empty_miso", mw, 16'hFFFF);
    check("empty_rx_data", rx_data, 16'h5A69);

    // Aborted after 9 rising edges, then a clean frame.
    spi_frame(16'hC3C3, 9, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("abort_rx_data_kept", rx_data, 16'h5A69);
    spi_frame(16'h1234, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("after_abort_rx_data", rx_data, 16'h1234);

    // Load at frame start (empty) and mid-frame (full, ignored).
    spi_frame(16'h0F0F, 16, 16, 1, 16'h1111, 8, 16'h2222, 0, mw);
    wait_drain();
    check("start_load_miso", mw, 16'hFFFF);
    check("start_load_held", tx_ready, 0);
    spi_frame(16'hF0F0, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("next_frame_miso", mw, 16'h1111);
    check("next_frame_rx", rx_data, 16'hF0F0);

    // Frame start with a full register and a colliding load.
    tx_load_word(16'h3333);
    spi_frame(16'h9999, 16, 16, 1, 16'h4444, 0, 16'h0, 0, mw);
    wait_drain();
    check("full_start_miso", mw, 16'h3333);
    check("full_start_load_ignored", tx_ready, 1);

    // Reset after 5 bits, with a word loaded mid-frame that reset must discard.
    spi_frame(16'hDEAD, 5, 16, 0, 16'h0, 3, 16'h7777, 2, mw);
    spi_frame(16'hBEEF, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("post_reset_miso", mw, 16'hFFFF);
    check("post_reset_rx", rx_data, 16'hBEEF);

    // Deselect arriving with the 16th rise still completes the frame.
    spi_frame(16'h6C6C, 16, 16, 0, 16'h0, 0, 16'h0, 1, mw);
    wait_drain();
    check("desel_at_rise_rx", rx_data, 16'h6C6C);
    check("desel_at_rise_oe", miso_oe, 0);

`ifdef SPI_RESPONDER_RX_HANDSHAKE_EN
    // Two frames with no rx_ack: the second overwrites and flags overrun.
    auto_ack = 1'b0;
    spi_frame(16'h0001, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("hs_first_valid", rx_valid, 1);
    exp_ovr = 1;
    spi_frame(16'h0002, 16, 16, 0, 16'h0, 0, 16'h0, 0, mw);
    wait_drain();
    check("hs_valid_held", rx_valid, 1);
    check("hs_rx_data", rx_data, 16'h0002);
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    check("hs_ack_clears", rx_valid, 0);
    auto_ack = 1'b1;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("frame_err_all_seen", exp_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
